// File: rtl/fifo_sr_pkg.sv
// Shared helpers for the multi-flow linked-list FIFO: constant math,
// derived field widths and tag extraction from a data word.
package fifo_sr_pkg;

    // Widest data word the tag helper accepts.
    localparam int WORD_MAX = 64;

    // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Tag field width; at least one bit, even for a single flow.
    function automatic int tag_width_of(input int flux);
        return max(1, clog2(flux));
    endfunction

    // Entry address width.
    function automatic int addr_width_of(input int depth);
        return max(1, clog2(depth));
    endfunction

    // Occupancy counter width; must be able to hold DEPTH itself.
    function automatic int cnt_width_of(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Flow tag carried in the top tag_width bits of a width-bit word.
    function automatic logic [31:0] tag_of(input logic [WORD_MAX-1:0] word,
                                           input int width,
                                           input int tag_width);
        logic [WORD_MAX-1:0] shifted;
        shifted = word >> (width - tag_width);
        return 32'(shifted & ((64'd1 << tag_width) - 64'd1));
    endfunction

endpackage

// File: rtl/fifo_sr_free_alloc.sv
// Free-entry allocator: picks the lowest-index free entry; when nothing is
// free it hands back the entry being released by this cycle's read so a
// full buffer still sustains one write per cycle.
module fifo_sr_free_alloc
    import fifo_sr_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = addr_width_of(DEPTH)
) (
    input  logic [DEPTH-1:0]      free_map,
    input  logic [ADDR_WIDTH-1:0] freed_addr,
    input  logic                  freed_vld,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_vld
);

    // Downward scan so the lowest free index wins; default is the reuse path.
    always_comb begin
        alloc_addr = freed_addr;
        alloc_vld  = freed_vld;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                alloc_addr = ADDR_WIDTH'(i);
                alloc_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_sr_ll_multi.sv
// Shared-memory multi-flow FIFO. One DEPTH-entry buffer holds all flows;
// each flow is a linked list (head, tail, count) threaded through nxt.
// One read (highest requesting non-empty flow) and one write per cycle.
module fifo_sr_ll_multi
    import fifo_sr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int FLUX     = 2,
    parameter int FLOW_MAX = DEPTH
) (
    input  logic                               ck,
    input  logic                               rst,
    input  logic                               wr,
    input  logic [WIDTH-1:0]                   datain,
    input  logic [FLUX-1:0]                    rd,
    output logic [WIDTH-1:0]                   dataout,
    output logic                               valid_out,
    output logic                               full,
    output logic [FLUX-1:0]                    empty,
    output logic [FLUX-1:0]                    flow_full,
    output logic [FLUX*(clog2(DEPTH)+1)-1:0]   count,
    output logic                               wr_drop,
    output logic                               rd_drop
);

    localparam int TAG_WIDTH  = tag_width_of(FLUX);
    localparam int ADDR_WIDTH = addr_width_of(DEPTH);
    localparam int CNT_WIDTH  = cnt_width_of(DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [TAG_WIDTH-1:0]  flow_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    addr_t            nxt_q [DEPTH];
    addr_t            nxt_d [DEPTH];
    logic [DEPTH-1:0] free_map_q, free_map_d;
    addr_t            head_q [FLUX];
    addr_t            head_d [FLUX];
    addr_t            tail_q [FLUX];
    addr_t            tail_d [FLUX];
    cnt_t             cnt_q [FLUX];
    cnt_t             cnt_d [FLUX];
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             valid_out_q, valid_out_d;
    logic             wr_drop_q, wr_drop_d;
    logic             rd_drop_q, rd_drop_d;

    logic        gnt_vld;
    flow_t       gnt_idx;
    addr_t       freed_addr;
    addr_t       alloc_addr;
    logic        alloc_vld;
    logic [31:0] tag_raw;
    logic        tag_ok;
    flow_t       tag;
    logic        cap_ok;
    logic        wr_acc;
    logic        tag_keeps_entries;

    // Status flags decoded purely from registered occupancy.
    always_comb begin
        empty     = '0;
        flow_full = '0;
        count     = '0;
        for (int i = 0; i < FLUX; i++) begin
            empty[i]                          = (cnt_q[i] == '0);
            flow_full[i]                      = (cnt_q[i] == cnt_t'(FLOW_MAX));
            count[i*CNT_WIDTH +: CNT_WIDTH]   = cnt_q[i];
        end
    end

    assign full = ~|free_map_q;

    // Read grant: highest-index flow that requests and holds data.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (rd[i] && !empty[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = flow_t'(i);
            end
        end
    end

    assign freed_addr = head_q[gnt_idx];

    fifo_sr_free_alloc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_alloc (
        .free_map   (free_map_q),
        .freed_addr (freed_addr),
        .freed_vld  (gnt_vld),
        .alloc_addr (alloc_addr),
        .alloc_vld  (alloc_vld)
    );

    // Write admission: valid tag, a slot (possibly the one being read out),
    // and room under the flow cap unless the same flow is being drained.
    always_comb begin
        tag_raw           = tag_of(WORD_MAX'(datain), WIDTH, TAG_WIDTH);
        tag_ok            = (tag_raw < 32'(FLUX));
        tag               = flow_t'(tag_raw);
        cap_ok            = !flow_full[tag] || (gnt_vld && (gnt_idx == tag));
        wr_acc            = wr && tag_ok && alloc_vld && cap_ok;
        tag_keeps_entries = (cnt_q[tag] != '0) &&
                            !(gnt_vld && (gnt_idx == tag) && (cnt_q[tag] == cnt_t'(1)));
    end

    // Next-state: read pops the head first, then the write links or re-seeds.
    always_comb begin
        mem_d       = mem_q;
        nxt_d       = nxt_q;
        free_map_d  = free_map_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        dataout_d   = dataout_q;
        valid_out_d = gnt_vld;
        rd_drop_d   = (|rd) && !gnt_vld;
        wr_drop_d   = wr && !wr_acc;

        if (gnt_vld) begin
            dataout_d              = mem_q[freed_addr];
            head_d[gnt_idx]        = nxt_q[freed_addr];
            cnt_d[gnt_idx]         = cnt_q[gnt_idx] - cnt_t'(1);
            free_map_d[freed_addr] = 1'b1;
        end

        // Clearing the slot after the read's release lets a full-buffer
        // write claim the entry that was just freed.
        if (wr_acc) begin
            mem_d[alloc_addr]      = datain;
            free_map_d[alloc_addr] = 1'b0;
            if (tag_keeps_entries) begin
                nxt_d[tail_q[tag]] = alloc_addr;
            end else begin
                head_d[tag] = alloc_addr;
            end
            tail_d[tag] = alloc_addr;
            cnt_d[tag]  = cnt_d[tag] + cnt_t'(1);
        end
    end

    // Control state and output register, cleared by async reset.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            free_map_q  <= '1;
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            dataout_q   <= '0;
            valid_out_q <= 1'b0;
            wr_drop_q   <= 1'b0;
            rd_drop_q   <= 1'b0;
        end else begin
            free_map_q  <= free_map_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            dataout_q   <= dataout_d;
            valid_out_q <= valid_out_d;
            wr_drop_q   <= wr_drop_d;
            rd_drop_q   <= rd_drop_d;
        end
    end

    // Storage and link pointers; contents are meaningless while free.
    always_ff @(posedge ck) begin
        mem_q <= mem_d;
        nxt_q <= nxt_d;
    end

    assign dataout   = dataout_q;
    assign valid_out = valid_out_q;
    assign wr_drop   = wr_drop_q;
    assign rd_drop   = rd_drop_q;

endmodule

// File: tb/tb_fifo_sr_ll_multi.sv
// Bench for fifo_sr_ll_multi: directed scenarios plus random traffic,
// checked against a queue-per-flow reference model.
module tb_fifo_sr_ll_multi;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int FLUX     = 2;
    localparam int FLOW_MAX = 6;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] datain = '0;
    logic [1:0] rd = '0;
    logic [7:0] dataout;
    logic       valid_out;
    logic       full;
    logic [1:0] empty;
    logic [1:0] flow_full;
    logic [7:0] count;
    logic       wr_drop;
    logic       rd_drop;

    fifo_sr_ll_multi #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .FLUX     (FLUX),
        .FLOW_MAX (FLOW_MAX)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .wr        (wr),
        .datain    (datain),
        .rd        (rd),
        .dataout   (dataout),
        .valid_out (valid_out),
        .full      (full),
        .empty     (empty),
        .flow_full (flow_full),
        .count     (count),
        .wr_drop   (wr_drop),
        .rd_drop   (rd_drop)
    );

    always #5 ck = ~ck;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: per-flow queues of data and of the entry each word
    // occupies, plus a free bitmap with lowest-index allocation.
    logic [7:0] mq [2][$];
    int         ma [2][$];
    bit   [7:0] mfree = 8'hFF;
    logic [7:0] e_dout  = '0;
    bit         e_valid = 1'b0;
    bit         e_wdrop = 1'b0;
    bit         e_rdrop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        for (int f = 0; f < FLUX; f++) begin
            mq[f].delete();
            ma[f].delete();
        end
        mfree   = 8'hFF;
        e_dout  = '0;
        e_valid = 1'b0;
        e_wdrop = 1'b0;
        e_rdrop = 1'b0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input logic [1:0] r);
        int  g, slot, tg, a;
        bit  gv, sv, acc;
        gv = 1'b0; g = 0;
        for (int f = 0; f < FLUX; f++)
            if (r[f] && mq[f].size() > 0) begin gv = 1'b1; g = f; end
        sv = 1'b0; slot = 0;
        for (int e = DEPTH - 1; e >= 0; e--)
            if (mfree[e]) begin sv = 1'b1; slot = e; end
        if (!sv && gv) begin sv = 1'b1; slot = ma[g][0]; end
        tg  = int'(d[7]);
        acc = w && sv && ((mq[tg].size() < FLOW_MAX) || (gv && g == tg));
        if (gv) begin
            e_dout   = mq[g].pop_front();
            a        = ma[g].pop_front();
            mfree[a] = 1'b1;
        end
        e_valid = gv;
        e_rdrop = (r != 2'b00) && !gv;
        e_wdrop = w && !acc;
        if (acc) begin
            mq[tg].push_back(d);
            ma[tg].push_back(slot);
            mfree[slot] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [1:0] e_empty, e_ff;
        for (int f = 0; f < FLUX; f++) begin
            e_empty[f] = (mq[f].size() == 0);
            e_ff[f]    = (mq[f].size() == FLOW_MAX);
        end
        chk("dataout",   dataout,   e_dout);
        chk("valid_out", valid_out, e_valid);
        chk("wr_drop",   wr_drop,   e_wdrop);
        chk("rd_drop",   rd_drop,   e_rdrop);
        chk("full",      full,      mfree == 8'h00);
        chk("empty",     empty,     e_empty);
        chk("flow_full", flow_full, e_ff);
        chk("count0",    count[3:0], mq[0].size());
        chk("count1",    count[7:4], mq[1].size());
        chk("free_map",  dut.free_map_q, mfree);
    endtask

    task automatic cyc(input bit w, input logic [7:0] d, input logic [1:0] r);
        wr = w; datain = d; rd = r;
        model_step(w, d, r);
        @(posedge ck);
        #1;
        compare_all();
        wr = 1'b0; rd = 2'b00;
    endtask

    // Asserted off-edge so the async clear is observed before any clock.
    task automatic do_reset();
        wr = 1'b0; rd = 2'b00;
        rst = 1'b1;
        model_clear();
        #2;
        compare_all();
        chk("rst_empty", empty, 2'b11);
        chk("rst_count", count, 8'h00);
        @(posedge ck);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge ck) begin
        if (!rst) begin
            int occ;
            occ = int'(count[3:0]) + int'(count[7:4]);
            assert (occ == $countones(~dut.free_map_q))
                else $error("FAIL occupancy_sum: cnt total %0d, used entries %0d",
                            occ, $countones(~dut.free_map_q));
        end
    end

    initial begin
        #1;
        do_reset();

        // Interleaved flows, then two reads of flow 0.
        cyc(1, 8'h01, 2'b00);
        cyc(1, 8'h81, 2'b00);
        cyc(1, 8'h02, 2'b00);
        cyc(1, 8'h82, 2'b00);
        cyc(0, 8'h00, 2'b01);
        chk("il_dout1", dataout, 8'h01);
        cyc(0, 8'h00, 2'b01);
        chk("il_dout2", dataout, 8'h02);
        chk("il_valid", valid_out, 1'b1);
        chk("il_cnt1", count[7:4], 4'd2);
        chk("il_freed", {dut.free_map_q[2], dut.free_map_q[0]}, 2'b11);

        // Both flows requested: flow 1 wins.
        cyc(1, 8'h03, 2'b00);
        cyc(0, 8'h00, 2'b11);
        chk("prio_dout", dataout, 8'h81);
        chk("prio_rdrop", rd_drop, 1'b0);
        chk("prio_cnt0", count[3:0], 4'd1);

        // Flow cap.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 8'(i), 2'b00);
        cyc(1, 8'h06, 2'b00);
        chk("cap_drop", wr_drop, 1'b1);
        chk("cap_cnt", count[3:0], 4'd6);
        cyc(1, 8'h06, 2'b01);
        chk("cap_rw_drop", wr_drop, 1'b0);
        chk("cap_rw_dout", dataout, 8'h00);
        chk("cap_rw_cnt", count[3:0], 4'd6);

        // Full buffer reuse.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 8'(i), 2'b00);
        cyc(1, 8'h80, 2'b00);
        cyc(1, 8'h81, 2'b00);
        chk("fr_full", full, 1'b1);
        cyc(1, 8'h90, 2'b10);
        chk("fr_dout", dataout, 8'h80);
        chk("fr_full2", full, 1'b1);
        chk("fr_slot", dut.mem_q[6], 8'h90);
        cyc(0, 8'h00, 2'b10);
        cyc(0, 8'h00, 2'b10);
        chk("fr_last", dataout, 8'h90);
        cyc(0, 8'h00, 2'b10);
        chk("fr_drained", rd_drop, 1'b1);

        // Empty-flow read and write into an empty flow.
        do_reset();
        cyc(1, 8'h81, 2'b00);
        cyc(0, 8'h00, 2'b10);
        cyc(0, 8'h00, 2'b01);
        chk("emp_rdrop", rd_drop, 1'b1);
        chk("emp_valid", valid_out, 1'b0);
        chk("emp_hold", dataout, 8'h81);
        cyc(1, 8'h05, 2'b00);
        chk("emp_clear", empty[0], 1'b0);

        // Reset mid-stream, then first write lands in entry 0.
        do_reset();
        cyc(1, 8'h11, 2'b00);
        cyc(1, 8'h92, 2'b00);
        cyc(1, 8'h13, 2'b00);
        cyc(1, 8'h94, 2'b00);
        cyc(1, 8'h15, 2'b10);
        cyc(1, 8'h16, 2'b00);
        do_reset();
        chk("mr_full", full, 1'b0);
        chk("mr_dout", dataout, 8'h00);
        cyc(1, 8'h42, 2'b00);
        chk("mr_entry0", dut.free_map_q, 8'hFE);

        // Random traffic: write-heavy, balanced, then read-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            bit         w;
            logic [7:0] d;
            logic [1:0] r;
            d = 8'($urandom);
            r = 2'($urandom);
            if (i < 1000)      w = ($urandom_range(0, 3) != 0);
            else if (i < 2000) w = ($urandom_range(0, 1) != 0);
            else               w = ($urandom_range(0, 3) == 0);
            if (i == 1500) do_reset();
            cyc(w, d, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sr_ll_multi.md
# fifo_sr_ll_multi

Shared-memory multi-flow FIFO: a single DEPTH-entry buffer holds interleaved traffic from FLUX flows, each flow kept as a linked list with its own head, tail and occupancy counter. The flow is selected by the tag in the MSBs of each written word. This block is the parametrised successor of the single-port shared-RAM flow FIFO in `src/fifo`. It adds a per-flow occupancy cap, free-slot reuse on simultaneous read/write when full, a registered output with a valid strobe, and drop indications.

## Interface
- WIDTH, 8: total word width, tag included.
- DEPTH, 8: shared entries, ≥2.
- FLUX, 2: number of flows, ≥2.
- FLOW_MAX, DEPTH: per-flow occupancy cap, 1..DEPTH.
- ck  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- datain  in  WIDTH  word; tag = datain[WIDTH-1 -: TAG_WIDTH], TAG_WIDTH = max(1, clog2(FLUX)).
- rd  in  FLUX  per-flow read request.
- dataout  out  WIDTH  registered read data, tag included.
- valid_out  out  1  dataout updated this cycle.
- full  out  1  no free entry.
- empty  out  FLUX  per-flow empty.
- flow_full  out  FLUX  per-flow count == FLOW_MAX.
- count  out  FLUX*(clog2(DEPTH)+1)  per-flow occupancy, flow i at slice i.
- wr_drop  out  1  one-cycle pulse: write rejected.
- rd_drop  out  1  one-cycle pulse: a read request was made only to empty flows.

## Operation
- State: mem[DEPTH], nxt[DEPTH] addresses, free_map[DEPTH], and per flow head, tail and cnt.
- Reset values: free_map all 1; cnt 0; dataout 0; valid_out 0; wr_drop 0; rd_drop 0; empty all 1; full 0; flow_full 0.
- full = ~|free_map. empty[i] = (cnt[i]==0). flow_full[i] = (cnt[i]==FLOW_MAX). All three are decoded from registered state only.
- Read grant: the highest index i with rd[i] & ~empty[i]. At most one read is granted per cycle.
- Granted read:
  - dataout <= mem[head[g]]; valid_out <= 1.
  - head[g] <= nxt[head[g]]; cnt[g]--; free_map[head[g]] <= 1.
- rd_drop: pulses when rd != 0 and no read is granted. An ungranted read leaves dataout holding its value and drives valid_out to 0.
- Write acceptance:
  - wr must be 1 and tag < FLUX.
  - A slot must be available: ~full, or a read is granted this cycle.
  - The tag's flow must be under its cap: ~flow_full[tag], or the granted read is on flow tag.
  - Otherwise wr_drop pulses and no state changes for the write.
- Slot choice: the lowest-index free entry. If full, the slot is the entry freed by this cycle's granted read, which is reused immediately.
- Accepted write, all on one edge:
  - mem[slot] <= datain; free_map[slot] <= 0.
  - If the flow stays non-empty after any same-cycle read: nxt[tail] <= slot and tail <= slot.
  - If the flow is empty, or it becomes empty from the same-cycle read (cnt==1 and that flow granted): head <= slot and tail <= slot.
  - cnt[tag] gets the net update: +1, -1, or unchanged when write and read hit the same flow.
- There is no bypass. A word becomes readable the cycle after it is written.

## Timing
- Read latency: 1 cycle. A grant at edge n gives dataout and valid_out after edge n.
- Throughput: one write and one read per cycle, sustained, including at full.
- Flags: full, empty and flow_full change the cycle after the causing edge.
- Reset: asserting rst mid-operation clears the flags and counters immediately. The contents of mem and nxt are discarded and are not reset.
- Sum of cnt always equals the popcount of ~free_map. An assertion in the bench checks this.

## Structure
- Package `fifo_sr_pkg` holds:
  - constant functions clog2 and max;
  - derived TAG_WIDTH, ADDR_WIDTH and CNT_WIDTH;
  - function tag_of(word).
- Sub-module `fifo_sr_free_alloc`: takes free_map plus the freed address/valid and returns the allocated address/valid. It is a lowest-index priority encoder with a full-reuse mux, and is purely combinational.
- The top level holds the linked-list state, counters, grant logic and the output register.

## Test plan
Configuration for all scenarios: WIDTH=8, DEPTH=8, FLUX=2, FLOW_MAX=6.
- Interleave: write 0x01, 0x81, 0x02, 0x82, then rd=2'b01 twice → dataout 0x01 then 0x02, each with valid_out=1; count flow1=2; entries 0 and 2 freed.
- Priority: both flows non-empty, rd=2'b11 → flow 1 head is read; flow 0 is untouched; rd_drop=0.
- Cap: write 0x00..0x05, then 0x06 on flow 0 → wr_drop=1 and count0 stays 6. The same write issued with rd=2'b01 → accepted, count0=6, and dataout is the old head 0x00.
- Full reuse: fill 8 entries (6 on flow 0, 2 on flow 1), then wr 0x90 with rd=2'b10 → 0x90 is stored in the slot freed by flow 1's head; full stays 1; a later read on flow 1 returns 0x90 last.
- Empty cases:
  - rd=2'b01 with flow 0 empty → rd_drop=1, valid_out=0, dataout unchanged.
  - Write to an empty flow → empty[i] deasserts the next cycle.
- Reset mid-stream: assert rst during traffic with 5 entries held → immediately empty=2'b11, full=0, count=0, dataout=0. The first write after reset lands in entry 0.
